// File: rtl/axi_pkg.sv
// Shared AXI types for the decode-error responder: response codes, channel FSM
// states and the burst-length field width.
package axi_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_decerr_slave_rd_ch.sv
// Read half of the decode-error responder: accepts one AR, then streams ARLEN+1
// DECERR beats carrying a constant fill pattern.
module decerr_rd_ch
  import axi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [AXI_LEN_W-1:0]  arlen_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i
);

  rd_state_t              state_q;
  logic                   arready_q;
  logic                   rvalid_q;
  logic                   rlast_q;
  logic [ID_WIDTH-1:0]    rid_q;
  logic [AXI_LEN_W-1:0]   beats_left_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= R_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rid_q        <= '0;
      beats_left_q <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (arvalid_i && arready_q) begin
            state_q      <= R_DATA;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b1;
            rlast_q      <= (arlen_i == '0);
            rid_q        <= arid_i;
            beats_left_q <= arlen_i;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rvalid_q && rready_i) begin
            if (rlast_q) begin
              state_q   <= R_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              // Last beat is flagged the cycle the counter reaches zero, so it never wraps.
              beats_left_q <= beats_left_q - 1'b1;
              rlast_q      <= (beats_left_q == AXI_LEN_W'(1));
            end
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rlast_q;
  assign rid_o     = rid_q;
  assign rdata_o   = RDATA_FILL;
  assign rresp_o   = DECERR;

endmodule

// File: rtl/axi_decerr_slave.sv
// Default crossbar target: completes any unmapped AXI4 access with DECERR so the
// master never hangs. Write FSM lives here; the read FSM is decerr_rd_ch.
module axi_decerr_slave
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [AXI_LEN_W-1:0]    AWLEN,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [AXI_LEN_W-1:0]    ARLEN,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  wr_state_t           wr_state_q;
  logic                awready_q;
  logic                wready_q;
  logic                bvalid_q;
  logic [ID_WIDTH-1:0] bid_q;

  // Address, length and write payload are accepted but carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR, AWLEN, WDATA, WSTRB, ARADDR};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (AWVALID && awready_q) begin
            wr_state_q <= W_DATA;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            bid_q      <= AWID;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          // Burst ends on WLAST alone; AWLEN is not cross-checked.
          if (WVALID && wready_q && WLAST) begin
            wr_state_q <= W_RESP;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
          end
        end
        W_RESP: begin
          if (bvalid_q && BREADY) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = DECERR;

  decerr_rd_ch #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .RDATA_FILL (RDATA_FILL)
  ) u_rd_ch (
    .clk_i     (ACLK),
    .rst_ni    (ARESETn),
    .arid_i    (ARID),
    .arlen_i   (ARLEN),
    .arvalid_i (ARVALID),
    .arready_o (ARREADY),
    .rid_o     (RID),
    .rdata_o   (RDATA),
    .rresp_o   (RRESP),
    .rlast_o   (RLAST),
    .rvalid_o  (RVALID),
    .rready_i  (RREADY)
  );

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed bench for axi_decerr_slave: one task per scenario, inline checks,
// inputs driven and outputs sampled 1 ns after each rising edge.
module tb_axi_decerr_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam logic [DW-1:0] FILL = 32'hDEAD_BEEF;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [IW-1:0] AWID, ARID, BID, RID;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic          BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_decerr_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RDATA_FILL(FILL)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    step(); step();
    checks++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP} !== {1'b0, 1'b0, 1'b0, 8'h00, 2'b11}) begin
      failures++;
      $display("FAIL reset_wr: got aw=%b w=%b bv=%b bid=%h bresp=%b want 0 0 0 00 11",
               AWREADY, WREADY, BVALID, BID, BRESP);
    end
    checks++;
    if ({ARREADY, RVALID, RLAST, RID, RDATA, RRESP} !== {1'b0, 1'b0, 1'b0, 8'h00, FILL, 2'b11}) begin
      failures++;
      $display("FAIL reset_rd: got ar=%b rv=%b rl=%b rid=%h rdata=%h rresp=%b want 0 0 0 00 %h 11",
               ARREADY, RVALID, RLAST, RID, RDATA, RRESP, FILL);
    end
    ARESETn = 1'b1;
    step();
    checks++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      failures++;
      $display("FAIL reset_release: got awready=%b arready=%b want 1 1", AWREADY, ARREADY);
    end
    $display("reset: done");
  endtask

  task automatic test_write_single();
    WVALID = 1'b1; WLAST = 1'b1;
    step();
    checks++;
    if (WREADY !== 1'b0) begin
      failures++;
      $display("FAIL w_before_aw: got wready=%b want 0", WREADY);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    AWID = 8'h15; AWVALID = 1'b1; BREADY = 1'b1;
    step();
    AWVALID = 1'b0;
    checks++;
    if ({AWREADY, WREADY, BVALID} !== 3'b010) begin
      failures++;
      $display("FAIL wr_after_aw: got aw=%b w=%b bv=%b want 0 1 0", AWREADY, WREADY, BVALID);
    end
    WVALID = 1'b1; WLAST = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF;
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    checks++;
    if ({BVALID, BID, BRESP, WREADY} !== {1'b1, 8'h15, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL wr_bresp: got bv=%b bid=%h bresp=%b wready=%b want 1 15 11 0",
               BVALID, BID, BRESP, WREADY);
    end
    step();
    checks++;
    if ({BVALID, AWREADY} !== 2'b01) begin
      failures++;
      $display("FAIL wr_turnaround: got bv=%b awready=%b want 0 1", BVALID, AWREADY);
    end
    BREADY = 1'b0;
    $display("write_single: id=15 done");
  endtask

  task automatic test_read_burst();
    ARID = 8'h2A; ARLEN = 8'd3; ARVALID = 1'b1; RREADY = 1'b1;
    step();
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ARREADY, RVALID, RLAST, RID, RDATA, RRESP} !== {1'b0, 1'b1, (i == 3), 8'h2A, FILL, 2'b11}) begin
        failures++;
        $display("FAIL rd_beat%0d: got ar=%b rv=%b rl=%b rid=%h rdata=%h rresp=%b want 0 1 %0d 2a %h 11",
                 i, ARREADY, RVALID, RLAST, RID, RDATA, RRESP, (i == 3), FILL);
      end
      step();
    end
    checks++;
    if ({RVALID, RLAST, ARREADY} !== 3'b001) begin
      failures++;
      $display("FAIL rd_end: got rv=%b rl=%b arready=%b want 0 0 1", RVALID, RLAST, ARREADY);
    end
    RREADY = 1'b0;
    $display("read_burst: id=2a len=3 done");
  endtask

  task automatic test_long_stall();
    int hs_count = 0;
    int stall_err = 0;
    int last_err = 0;
    int cyc = 0;
    logic hs;
    logic [IW-1:0] rid_prev;
    logic [DW-1:0] rdata_prev;
    logic rlast_prev;
    ARID = 8'h63; ARLEN = 8'd255; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    while (hs_count < 256 && cyc < 3000) begin
      RREADY = 1'($urandom_range(0, 1));
      #1;
      hs = RVALID && RREADY;
      if (RVALID && (RLAST !== (hs_count == 255))) last_err++;
      rid_prev = RID; rdata_prev = RDATA; rlast_prev = RLAST;
      step();
      cyc++;
      if (hs) hs_count++;
      else if (RVALID !== 1'b1 || RID !== rid_prev || RDATA !== rdata_prev || RLAST !== rlast_prev)
        stall_err++;
    end
    checks++;
    if (hs_count !== 256) begin
      failures++;
      $display("FAIL stall_count: got handshakes=%0d want 256", hs_count);
    end
    checks++;
    if (last_err !== 0) begin
      failures++;
      $display("FAIL stall_rlast: got misplaced_rlast=%0d want 0", last_err);
    end
    checks++;
    if (stall_err !== 0) begin
      failures++;
      $display("FAIL stall_stable: got unstable_stalls=%0d want 0", stall_err);
    end
    checks++;
    if ({RVALID, ARREADY} !== 2'b01) begin
      failures++;
      $display("FAIL stall_end: got rv=%b arready=%b want 0 1", RVALID, ARREADY);
    end
    RREADY = 1'b0;
    $display("long_stall: handshakes=%0d cycles=%0d", hs_count, cyc);
  endtask

  task automatic test_wlast_early();
    AWID = 8'h3C; AWLEN = 8'd7; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      WVALID = 1'b1; WLAST = (i == 3);
      step();
      checks++;
      if ({WREADY, BVALID} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL wlast_beat%0d: got wready=%b bvalid=%b want %b", i, WREADY, BVALID,
                 ((i == 3) ? 2'b01 : 2'b10));
      end
    end
    WLAST = 1'b0;
    step(); step();
    checks++;
    if ({WREADY, BVALID, BID} !== {1'b0, 1'b1, 8'h3C}) begin
      failures++;
      $display("FAIL wlast_no_more_w: got wready=%b bv=%b bid=%h want 0 1 3c", WREADY, BVALID, BID);
    end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    step();
    checks++;
    if ({WREADY, BVALID, AWREADY} !== 3'b001) begin
      failures++;
      $display("FAIL wlast_idle: got wready=%b bv=%b awready=%b want 0 0 1", WREADY, BVALID, AWREADY);
    end
    WVALID = 1'b0;
    $display("wlast_early: awlen=7 beats=3 done");
  endtask

  task automatic test_concurrent();
    int rcount = 0;
    int b_err = 0;
    int rl_err = 0;
    logic hs;
    AWID = 8'h77; AWVALID = 1'b1; ARID = 8'h11; ARLEN = 8'd2; ARVALID = 1'b1;
    RREADY = 1'b1; BREADY = 1'b0;
    step();
    AWVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if ({AWREADY, ARREADY, WREADY, RVALID} !== 4'b0011) begin
      failures++;
      $display("FAIL conc_accept: got aw=%b ar=%b w=%b rv=%b want 0 0 1 1", AWREADY, ARREADY, WREADY, RVALID);
    end
    WVALID = 1'b1; WLAST = 1'b1;
    for (int c = 0; c < 10; c++) begin
      hs = RVALID && RREADY;
      if (RVALID && (RLAST !== (rcount == 2))) rl_err++;
      step();
      if (c == 0) begin WVALID = 1'b0; WLAST = 1'b0; end
      if (hs) rcount++;
      if (BVALID !== 1'b1 || BID !== 8'h77) b_err++;
    end
    checks++;
    if (rcount !== 3 || rl_err !== 0 || ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL conc_read: got beats=%0d rlast_err=%0d arready=%b want 3 0 1", rcount, rl_err, ARREADY);
    end
    checks++;
    if (b_err !== 0) begin
      failures++;
      $display("FAIL conc_bhold: got bad_b_cycles=%0d want 0", b_err);
    end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin
      failures++;
      $display("FAIL conc_bdone: got bvalid=%b want 0", BVALID);
    end
    RREADY = 1'b0;
    $display("concurrent: read_beats=%0d b_held=10", rcount);
  endtask

  task automatic test_reset_mid();
    ARID = 8'h44; ARLEN = 8'd5; ARVALID = 1'b1; RREADY = 1'b1;
    step();
    ARVALID = 1'b0;
    step();
    checks++;
    if ({RVALID, RLAST} !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_beat2: got rv=%b rl=%b want 1 0", RVALID, RLAST);
    end
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if ({RVALID, ARREADY, AWREADY} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_async: got rv=%b ar=%b aw=%b want 0 0 0", RVALID, ARREADY, AWREADY);
    end
    step();
    ARESETn = 1'b1;
    RREADY = 1'b0;
    step();
    checks++;
    if ({ARREADY, RVALID} !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_release: got arready=%b rv=%b want 1 0", ARREADY, RVALID);
    end
    ARID = 8'h5A; ARLEN = 8'd0; ARVALID = 1'b1; RREADY = 1'b1;
    step();
    ARVALID = 1'b0;
    checks++;
    if ({RVALID, RLAST, RID, RDATA} !== {1'b1, 1'b1, 8'h5A, FILL}) begin
      failures++;
      $display("FAIL rstmid_single: got rv=%b rl=%b rid=%h rdata=%h want 1 1 5a %h",
               RVALID, RLAST, RID, RDATA, FILL);
    end
    step();
    checks++;
    if ({RVALID, ARREADY} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_end: got rv=%b arready=%b want 0 1", RVALID, ARREADY);
    end
    RREADY = 1'b0;
    $display("reset_mid: recovery read id=5a done");
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_burst();
    test_long_stall();
    test_wlast_early();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
Default responder behind the crossbar's slave-select path. Any AW/AR whose address hits no entry in the address map is routed here. The block completes the transaction to AXI4 protocol with DECERR responses, so an unmapped access never hangs a master. Write and read channels are independent and each handles one outstanding transaction.

Parameters:
ADDR_WIDTH, 32, AW/AR address width (address is accepted but ignored)
DATA_WIDTH, 32, W/R data width
ID_WIDTH, 8, AXI ID width including crossbar-appended master index bits
RDATA_FILL, 0, constant driven on RDATA for every read beat (DATA_WIDTH bits)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWID  in  ID_WIDTH  write ID
AWADDR  in  ADDR_WIDTH  write address, unused
AWLEN  in  8  burst length-1, informational only
AWVALID  in  1  AW valid
AWREADY  out  1  AW ready
WDATA  in  DATA_WIDTH  discarded
WSTRB  in  DATA_WIDTH/8  discarded
WLAST  in  1  last write beat
WVALID  in  1  W valid
WREADY  out  1  W ready
BID  out  ID_WIDTH  response ID
BRESP  out  2  write response
BVALID  out  1  B valid
BREADY  in  1  B ready
ARID  in  ID_WIDTH  read ID
ARADDR  in  ADDR_WIDTH  read address, unused
ARLEN  in  8  burst length-1
ARVALID  in  1  AR valid
ARREADY  out  1  AR ready
RID  out  ID_WIDTH  read ID
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RLAST  out  1  last read beat
RVALID  out  1  R valid
RREADY  in  1  R ready

Behaviour:
- One clock, ACLK. ARESETn is asynchronous assert, active-low. All state is reset immediately on assertion.
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=2'b11, ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=RDATA_FILL, RRESP=2'b11. All ready/valid outputs are registered.
- First ACLK edge after reset release: AWREADY=1 and ARREADY=1 (both FSMs in IDLE).
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY at edge T, capture AWID, go to W_DATA. At T+1: AWREADY=0, WREADY=1.
  - W_DATA: WREADY=1. Every W handshake is discarded. Termination is by WLAST only; AWLEN is not checked. On WVALID&WREADY&WLAST at T, go to W_RESP. At T+1: WREADY=0, BVALID=1, BID=captured ID, BRESP=2'b11.
  - W_RESP: hold BVALID/BID/BRESP stable until BREADY. On BVALID&BREADY at T, go to W_IDLE. At T+1: BVALID=0, AWREADY=1.
  - W beats arriving before AW are not accepted (WREADY=0 outside W_DATA).
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake at T, capture ARID and ARLEN into an 8-bit down-counter beats_left, go to R_DATA. At T+1: ARREADY=0, RVALID=1, RLAST=(ARLEN==0).
  - R_DATA: RDATA=RDATA_FILL, RRESP=2'b11, RID=captured ID. Each beat is held stable while RREADY=0.
  - On RVALID&RREADY with RLAST=0: decrement beats_left. RLAST=1 on the next cycle exactly when beats_left becomes 0.
  - On RVALID&RREADY with RLAST=1: go to R_IDLE. At the next edge: RVALID=0, RLAST=0, ARREADY=1.
  - ARLEN=255 gives 256 beats; the counter never wraps.
- Throughput: back-to-back R beats, one per cycle, when RREADY is held high.
- Minimum turnaround per channel is one idle cycle between a transaction's final handshake and the next AW/AR acceptance.
- Write and read proceed concurrently with no interaction. Simultaneous AW and AR at the same edge are both accepted.
- Reset mid-burst: both FSMs go to IDLE; all valids drop asynchronously; no partial response is resumed.

Decomposition:
- Shared package axi_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - wr_state_t and rd_state_t enums
  - AXI_LEN_W=8 constant
- One sub-module: decerr_rd_ch, containing the read FSM and beat counter. The write FSM stays in the top module.

Test Plan:
1. AWID=8'h15, single W beat with WLAST=1, BREADY=1 -> BVALID exactly 2 cycles after the AW handshake; BID=8'h15, BRESP=2'b11; AWREADY back to 1 the cycle after the B handshake.
2. ARID=8'h2A, ARLEN=3, RREADY=1 -> RVALID for 4 consecutive cycles starting the cycle after AR; RLAST only on beat 4; RRESP=2'b11 and RDATA=RDATA_FILL on every beat; then ARREADY=1.
3. ARLEN=255, RREADY toggling 1/0 randomly -> exactly 256 handshakes with RLAST on the 256th; RID/RDATA stable across every stall.
4. AWLEN=7 but WLAST on beat 3 -> B issued after beat 3; no further WREADY until a new AW is accepted.
5. AW and AR accepted at the same edge, BREADY=0 for 10 cycles -> read burst completes unaffected; BVALID held with constant BID until BREADY rises.
6. ARESETn pulsed low during beat 2 of an ARLEN=5 burst -> RVALID=0 immediately; after release ARREADY=1 and a new ARLEN=0 read returns one beat with RLAST=1.
